// File: rtl/neuron_core_param.sv
// neuron_core_param: time-multiplexed LIF neuron core with per-neuron state in a single-port memory.
// Optional refractory counter enabled by defining NEURON_CORE_PARAM_REFRACTORY_EN.
module neuron_core_param #(
    parameter int N  = 256,
    parameter int M  = 8,
    parameter int W  = 12,
    parameter int WB = 4
) (
    input  logic              CLK,
    input  logic              RST_sync,
    input  logic              EV_REQ,
    output logic              EV_ACK,
    input  logic [M-1:0]      EV_ADDR,
    input  logic              EV_LEAK,
    input  logic [WB-1:0]     EV_WEIGHT,
    input  logic              EV_SIGN,
    output logic              SPK_VALID,
    output logic [M-1:0]      SPK_ADDR,
    input  logic              SPK_READY,
    input  logic              PROG_REQ,
    output logic              PROG_ACK,
    input  logic [M-1:0]      PROG_ADDR,
`ifdef NEURON_CORE_PARAM_REFRACTORY_EN
    input  logic [2*W+WB+4:0] PROG_DATA,
`else
    input  logic [2*W+WB:0]   PROG_DATA,
`endif
    output logic              BUSY,
    output logic [W-1:0]      V_MONITOR
);
    localparam int BW = 2*W+WB+1;
`ifdef NEURON_CORE_PARAM_REFRACTORY_EN
    localparam int DW = BW+4;
`else
    localparam int DW = BW;
`endif

    typedef enum logic [2:0] {IDLE, READ, UPDATE, SPIKE, DONE} state_t;

    logic [DW-1:0] mem [N];
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] upd_word;
    logic [M-1:0]  mem_wa;
    logic          mem_we, mem_re;
    state_t        state_q, state_d;
    logic [M-1:0]  addr_q, addr_d;
    logic          leak_q, leak_d, sign_q, sign_d, prog_q, prog_d;
    logic [WB-1:0] wt_q, wt_d;
    logic [W-1:0]  vmon_q, vmon_d;
    logic [W-1:0]  v_old, thr, sub_amt, v_sub, v_calc, v_new;
    logic [WB-1:0] lk;
    logic          dis, hold, fire, ev_in_range, prog_in_range;
    logic [W:0]    sum;
`ifdef NEURON_CORE_PARAM_REFRACTORY_EN
    logic [3:0]    ref_per [N];
    logic [3:0]    ref_cnt;
    assign ref_cnt = mem_rdata[DW-1 -: 4];
`endif

    assign {dis, lk, thr, v_old} = mem_rdata[BW-1:0];
    assign ev_in_range   = int'(EV_ADDR) < N;
    assign prog_in_range = int'(PROG_ADDR) < N;

    assign EV_ACK    = state_q == DONE && !prog_q;
    assign PROG_ACK  = state_q == DONE && prog_q;
    assign BUSY      = state_q != IDLE;
    assign SPK_VALID = state_q == SPIKE;
    assign SPK_ADDR  = SPK_VALID ? addr_q : '0;
    assign V_MONITOR = vmon_q;

    // neuron update: saturating add / floored subtract, threshold test and refractory bookkeeping
    always_comb begin
        sum     = {1'b0, v_old} + {{(W+1-WB){1'b0}}, wt_q};
        sub_amt = leak_q ? {{(W-WB){1'b0}}, lk} : {{(W-WB){1'b0}}, wt_q};
        v_sub   = v_old > sub_amt ? v_old - sub_amt : '0;
        v_calc  = (leak_q || sign_q) ? v_sub : (sum[W] ? '1 : sum[W-1:0]);
        hold    = dis;
`ifdef NEURON_CORE_PARAM_REFRACTORY_EN
        hold    = dis || (ref_cnt != 4'd0 && !leak_q);
`endif
        fire    = !hold && !leak_q && !sign_q && thr != '0 && v_calc >= thr;
        v_new   = hold ? v_old : (fire ? '0 : v_calc);
        upd_word = mem_rdata;
        upd_word[W-1:0] = v_new;
`ifdef NEURON_CORE_PARAM_REFRACTORY_EN
        upd_word[DW-1 -: 4] = fire ? ref_per[addr_q] : ((leak_q && ref_cnt != 4'd0) ? ref_cnt - 4'd1 : ref_cnt);
`endif
    end

    // FSM next state, event latching and memory port control
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        leak_d  = leak_q;
        sign_d  = sign_q;
        wt_d    = wt_q;
        prog_d  = prog_q;
        vmon_d  = vmon_q;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        mem_wa  = addr_q;
        mem_wd  = upd_word;
        case (state_q)
            IDLE: begin
                if (PROG_REQ) begin
                    mem_we  = prog_in_range;
                    mem_wa  = PROG_ADDR;
`ifdef NEURON_CORE_PARAM_REFRACTORY_EN
                    mem_wd  = {4'd0, PROG_DATA[BW-1:0]};
`else
                    mem_wd  = PROG_DATA;
`endif
                    prog_d  = 1'b1;
                    state_d = DONE;
                end else if (EV_REQ) begin
                    addr_d  = EV_ADDR;
                    leak_d  = EV_LEAK;
                    sign_d  = EV_SIGN;
                    wt_d    = EV_WEIGHT;
                    prog_d  = 1'b0;
                    state_d = ev_in_range ? READ : DONE;
                end
            end
            READ: begin
                mem_re  = 1'b1;
                state_d = UPDATE;
            end
            UPDATE: begin
                mem_we  = 1'b1;
                vmon_d  = v_new;
                state_d = fire ? SPIKE : DONE;
            end
            SPIKE:   state_d = SPK_READY ? DONE : SPIKE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // single-port state memory; a write coinciding with reset is dropped so the word survives
    always_ff @(posedge CLK) begin
        if (mem_we && !RST_sync) mem[mem_wa] <= mem_wd;
        if (mem_re) mem_rdata <= mem[addr_q];
`ifdef NEURON_CORE_PARAM_REFRACTORY_EN
        if (state_q == IDLE && PROG_REQ && prog_in_range && !RST_sync) ref_per[PROG_ADDR] <= PROG_DATA[DW-1 -: 4];
`endif
    end

    // FSM and event registers
    always_ff @(posedge CLK) begin
        if (RST_sync) begin
            state_q <= IDLE;
            addr_q  <= '0;
            leak_q  <= 1'b0;
            sign_q  <= 1'b0;
            wt_q    <= '0;
            prog_q  <= 1'b0;
            vmon_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            leak_q  <= leak_d;
            sign_q  <= sign_d;
            wt_q    <= wt_d;
            prog_q  <= prog_d;
            vmon_q  <= vmon_d;
        end
    end
endmodule

// File: tb/tb_neuron_core_param.sv
// tb_neuron_core_param: scoreboard bench for neuron_core_param (N=200).
module tb_neuron_core_param;
    localparam int N = 200, M = 8, W = 12, WB = 4;
`ifdef NEURON_CORE_PARAM_REFRACTORY_EN
    localparam int PW = 2*W+WB+5;
`else
    localparam int PW = 2*W+WB+1;
`endif

    logic          CLK = 0, RST_sync = 1, EV_REQ = 0, EV_LEAK = 0, EV_SIGN = 0;
    logic          SPK_READY = 1, PROG_REQ = 0;
    logic [M-1:0]  EV_ADDR = '0, PROG_ADDR = '0;
    logic [WB-1:0] EV_WEIGHT = '0;
    logic [PW-1:0] PROG_DATA = '0;
    logic          EV_ACK, SPK_VALID, PROG_ACK, BUSY;
    logic [M-1:0]  SPK_ADDR;
    logic [W-1:0]  V_MONITOR;

    neuron_core_param #(.N(N), .M(M), .W(W), .WB(WB)) dut (
        .CLK(CLK), .RST_sync(RST_sync), .EV_REQ(EV_REQ), .EV_ACK(EV_ACK), .EV_ADDR(EV_ADDR),
        .EV_LEAK(EV_LEAK), .EV_WEIGHT(EV_WEIGHT), .EV_SIGN(EV_SIGN), .SPK_VALID(SPK_VALID),
        .SPK_ADDR(SPK_ADDR), .SPK_READY(SPK_READY), .PROG_REQ(PROG_REQ), .PROG_ACK(PROG_ACK),
        .PROG_ADDR(PROG_ADDR), .PROG_DATA(PROG_DATA), .BUSY(BUSY), .V_MONITOR(V_MONITOR)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0, n_bad = 0;
    int ack_q[$];
    int spk_q[$];
    int mv[N], mthr[N], mlk[N], mdis[N];
    int mvmon = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_prog(input int a, input int dis, input int lk, input int thr, input int v);
        PROG_ADDR = M'(a);
        PROG_DATA = '0;
        PROG_DATA[2*W+WB:0] = {dis[0], lk[WB-1:0], thr[W-1:0], v[W-1:0]};
        mv[a] = v; mthr[a] = thr; mlk[a] = lk; mdis[a] = dis;
    endtask

    task automatic prog(input int a, input int dis, input int lk, input int thr, input int v);
        int lat = 0;
        set_prog(a, dis, lk, thr, v);
        PROG_REQ = 1;
        do begin
            @(negedge CLK);
            lat++;
        end while (!PROG_ACK && lat < 20);
        check("prog_lat", lat, 1);
        PROG_REQ = 0;
        @(negedge CLK);
    endtask

    // model the event, push expectations, drive it and compare what comes out
    task automatic send_ev(input int a, input bit lk, input int wt, input bit sg, input int stall, input string tag);
        int lat = 0, held = 0, hs = -1, nv = 0, exp_lat = 1;
        bit spk = 0;
        if (a < N) begin
            if (mdis[a] != 0) nv = mv[a];
            else if (lk) nv = mv[a] > mlk[a] ? mv[a] - mlk[a] : 0;
            else if (sg) nv = mv[a] > wt ? mv[a] - wt : 0;
            else nv = mv[a] + wt > 4095 ? 4095 : mv[a] + wt;
            spk = mdis[a] == 0 && !lk && !sg && mthr[a] != 0 && nv >= mthr[a];
            if (spk) begin
                nv = 0;
                spk_q.push_back(a);
            end
            mv[a] = nv;
            mvmon = nv;
            exp_lat = spk ? 4 + stall : 3;
        end
        ack_q.push_back(mvmon);
        EV_ADDR = M'(a); EV_LEAK = lk; EV_WEIGHT = WB'(wt); EV_SIGN = sg;
        SPK_READY = (stall == 0);
        EV_REQ = 1;
        do begin
            @(negedge CLK);
            lat++;
            if (SPK_VALID) begin
                if (held < stall) begin
                    held++;
                    check({tag, "_hold_addr"}, SPK_ADDR, a);
                    check({tag, "_hold_noack"}, EV_ACK, 0);
                end else begin
                    SPK_READY = 1;
                    hs = lat;
                    check({tag, "_spk_addr"}, SPK_ADDR, spk_q.size() > 0 ? spk_q.pop_front() : -1);
                end
            end
        end while (!EV_ACK && lat < 40);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_vmon"}, V_MONITOR, ack_q.size() > 0 ? ack_q.pop_front() : -1);
        check({tag, "_spiked"}, hs >= 0, spk);
        if (spk) check({tag, "_ack_after_hs"}, lat - hs, 1);
        EV_REQ = 0;
        SPK_READY = 1;
        @(negedge CLK);
        check({tag, "_idle"}, BUSY, 0);
    endtask

    initial begin
        int pa = -1, ea = -1;
        repeat (3) @(negedge CLK);
        check("rst_busy", BUSY, 0);
        check("rst_evack", EV_ACK, 0);
        check("rst_progack", PROG_ACK, 0);
        check("rst_spkv", SPK_VALID, 0);
        check("rst_spka", SPK_ADDR, 0);
        check("rst_vmon", V_MONITOR, 0);
        RST_sync = 0;
        @(negedge CLK);

        prog(5, 0, 2, 20, 0);
        send_ev(5, 0, 5, 0, 0, "n5_e1");
        send_ev(5, 0, 5, 0, 0, "n5_e2");
        send_ev(5, 0, 5, 0, 0, "n5_e3");
        send_ev(5, 0, 5, 0, 10, "n5_spk");
        send_ev(5, 1, 0, 0, 0, "n5_leak");

        prog(6, 0, 0, 0, 4090);
        send_ev(6, 0, 15, 0, 0, "sat_hi");
        prog(8, 0, 0, 0, 3);
        send_ev(8, 0, 15, 1, 0, "sat_lo");
        prog(9, 0, 2, 0, 1);
        send_ev(9, 1, 0, 0, 0, "leak_floor");
        prog(10, 1, 0, 20, 50);
        send_ev(10, 0, 15, 0, 0, "disabled");
        send_ev(210, 0, 7, 0, 0, "oor");

        set_prog(11, 0, 0, 0, 7);
        mv[11] = 10;
        mvmon = 10;
        ack_q.push_back(10);
        EV_ADDR = 8'd11; EV_LEAK = 0; EV_WEIGHT = 4'd3; EV_SIGN = 0;
        PROG_REQ = 1;
        EV_REQ = 1;
        for (int c = 1; c <= 40 && ea < 0; c++) begin
            @(negedge CLK);
            if (PROG_ACK) begin
                pa = c;
                PROG_REQ = 0;
            end
            if (EV_ACK) begin
                ea = c;
                check("arb_vmon", V_MONITOR, ack_q.pop_front());
            end
        end
        check("arb_prog_ack", pa, 1);
        check("arb_ev_ack", ea, 5);
        EV_REQ = 0;
        @(negedge CLK);

        prog(7, 0, 0, 0, 100);
        EV_ADDR = 8'd7; EV_LEAK = 0; EV_WEIGHT = 4'd5; EV_SIGN = 0;
        EV_REQ = 1;
        repeat (2) @(negedge CLK);
        check("mid_busy", BUSY, 1);
        RST_sync = 1;
        @(negedge CLK);
        check("mid_rst_busy", BUSY, 0);
        check("mid_rst_evack", EV_ACK, 0);
        check("mid_rst_progack", PROG_ACK, 0);
        check("mid_rst_spkv", SPK_VALID, 0);
        check("mid_rst_spka", SPK_ADDR, 0);
        check("mid_rst_vmon", V_MONITOR, 0);
        RST_sync = 0;
        EV_REQ = 0;
        @(negedge CLK);
        send_ev(7, 0, 0, 0, 0, "n7_readback");

        check("sb_ack_empty", ack_q.size(), 0);
        check("sb_spk_empty", spk_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
